arb_vrp_dispatch: RTL
=====================

// Module: arb_vrp_dispatch
// PURPOSE
//   One-to-many counterpart of the valid/ready/payload matrix arbiter. Takes one
//   upstream vld/rdy/pld stream and dispatches each beat to exactly one of WIDTH
//   downstream ports. The target is chosen by an internal least-recently-used
//   priority matrix over the enabled ports. A one-entry registered hold stage
//   sits between the upstream and downstream sides. Used to spread work across
//   parallel engines.
// PARAMETERS
//   WIDTH      4   number of downstream ports (>=2)
//   PLD_WIDTH  32  payload width in bits
// PORTS
//   clk      in   1                    clock; single clock domain
//   rst_n    in   1                    synchronous, active-low reset
//   v_en     in   WIDTH                per-port dispatch enable mask
//   vld_s    in   1                    upstream valid
//   rdy_s    out  1                    upstream ready
//   pld_s    in   PLD_WIDTH            upstream payload
//   v_vld_m  out  WIDTH                downstream valid; one-hot or zero
//   v_rdy_m  in   WIDTH                downstream ready
//   v_pld_m  out  PLD_WIDTH [WIDTH-1:0] downstream payload; held beat on all ports
// BEHAVIOUR
//   - State:
//       hold_vld (1b), hold_pld (PLD_WIDTH), hold_sel (one-hot WIDTH),
//       prio[WIDTH][WIDTH] matrix.
//   - prio[i][j]=1 means i wins over j. Diagonal is always 0.
//     prio[i][j] == ~prio[j][i] for every i!=j.
//   - Reset (rst_n=0 at posedge):
//       hold_vld=0, hold_pld=0, hold_sel=0.
//       prio[i][j]=1 for every i<j, so port 0 is highest.
//       An in-flight beat is dropped.
//   - Outputs:
//       v_vld_m = hold_sel & {WIDTH{hold_vld}}, so 0 out of reset.
//       v_pld_m[k] = hold_pld for all k.
//   - Grant (combinational):
//       gnt[i] = v_en[i] & AND over j!=i of (~v_en[j] | prio[i][j]).
//       gnt is one-hot when v_en!=0, else zero.
//   - Fire conditions:
//       out_fire = hold_vld & |(hold_sel & v_rdy_m).
//       in_fire  = vld_s & rdy_s.
//   - rdy_s = (|v_en) & (~hold_vld | out_fire). rdy_s may depend combinationally
//     on v_rdy_m; v_vld_m never depends on v_rdy_m.
//   - On in_fire: hold_pld<=pld_s, hold_sel<=gnt, hold_vld<=1.
//     The prio update for the granted port k is:
//       row k cleared; column k set (excluding prio[k][k]).
//     Port k becomes lowest priority.
//   - On out_fire without in_fire: hold_vld<=0. hold_pld and hold_sel keep their
//     values.
//   - out_fire and in_fire in the same cycle load the new beat. This gives
//     back-to-back throughput of 1 beat/cycle.
//   - Latency: one cycle from in_fire to v_vld_m asserted.
//   - Stall rules:
//       While waiting on v_rdy_m, the held beat keeps hold_sel and hold_pld
//       stable; no retargeting.
//       Changes to v_en affect only beats not yet captured.
//       v_en==0 forces rdy_s=0, which stalls upstream. The held beat still
//       drains.
//   - prio is unchanged in cycles without in_fire.
// STRUCTURE
//   - Sub-module arb_lru_matrix (WIDTH):
//       inputs  clk, rst_n, req (=v_en), upd (=in_fire)
//       output  gnt (one-hot)
//       owns the prio matrix and its update.
//   - The top level holds the hold register and the handshake logic.
//   - Shared package arb_pkg:
//       function prio_init(WIDTH) returns the upper-triangular reset matrix.
//       typedef for the one-hot select width.
// TESTING (WIDTH=4, PLD_WIDTH=32)
//   1 Reset, v_en=4'b1111, v_rdy_m=4'b1111, pld 0xA0..0xA4 back-to-back
//     -> dests 0,1,2,3,0 on consecutive cycles; rdy_s held 1.
//   2 v_en=4'b1010, 4 beats
//     -> dests 1,3,1,3; v_vld_m[0] and v_vld_m[2] never asserted.
//   3 Beat 0x55 to port 2, v_rdy_m[2]=0 for 3 cycles
//     -> v_vld_m=4'b0100 with pld 0x55 stable and rdy_s=0.
//     Release -> next beat captured in the same cycle.
//   4 v_en=0 with vld_s=1
//     -> rdy_s=0 and v_vld_m=0 indefinitely.
//     Set v_en=4'b0001 -> beat dispatched to port 0 one cycle later.
//   5 Beat held at port 3, then rst_n=0 for 1 cycle
//     -> v_vld_m=0 next cycle; next beat goes to port 0.
//   6 Beat held at port 1, v_en changed to 4'b0001 while stalled
//     -> held beat still completes on port 1; following beat goes to port 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration types and the reset priority matrix for the LRU dispatch slice.
package arb_pkg;

  localparam int ARB_MAX_W = 16;

  // One-hot port select, sized for the widest supported arbiter.
  typedef logic [ARB_MAX_W-1:0] sel_t;
  typedef sel_t [ARB_MAX_W-1:0] prio_mat_t;

  // Upper-triangular matrix: lower index beats higher index, so port 0 starts highest.
  function automatic prio_mat_t prio_init(input int width);
    prio_mat_t m;
    m = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      for (int j = 0; j < ARB_MAX_W; j++) begin
        if (i < width && j < width && i < j) m[i][j] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/arb_vrp_dispatch_if.sv
// Upstream vld/rdy/pld stream plus WIDTH downstream ports and the dispatch enable mask.
interface arb_vrp_dispatch_if #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
);
  logic [WIDTH-1:0]                v_en;
  logic                            vld_s;
  logic                            rdy_s;
  logic [PLD_WIDTH-1:0]            pld_s;
  logic [WIDTH-1:0]                v_vld_m;
  logic [WIDTH-1:0]                v_rdy_m;
  logic [WIDTH-1:0][PLD_WIDTH-1:0] v_pld_m;

  modport master (
    output v_en, vld_s, pld_s, v_rdy_m,
    input  rdy_s, v_vld_m, v_pld_m
  );

  modport slave (
    input  v_en, vld_s, pld_s, v_rdy_m,
    output rdy_s, v_vld_m, v_pld_m
  );
endinterface

// File: rtl/arb_lru_matrix.sv
// Least-recently-used priority matrix arbiter over the requesting ports.
// Latency: grant is combinational from req; the matrix updates on the clock after upd.
// Backpressure: none; upd is only asserted when the granted beat is actually captured.
module arb_lru_matrix
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             upd,
  output logic [WIDTH-1:0] gnt
);

  localparam prio_mat_t PRIO_RST = prio_init(WIDTH);

  // prio[i][j] = 1 means port i beats port j
  logic [WIDTH-1:0] prio [WIDTH];

  always_comb begin
    gnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gnt[i] = req[i];
      for (int j = 0; j < WIDTH; j++) begin
        if (j != i && req[j] && !prio[i][j]) gnt[i] = 1'b0;
      end
    end
  end

  // Winner drops to lowest: its row clears, its column sets; the diagonal stays 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        prio[i] <= PRIO_RST[i][WIDTH-1:0];
      end
    end else if (upd) begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (gnt[i])      prio[i][j] <= 1'b0;
          else if (gnt[j]) prio[i][j] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_vrp_dispatch.sv
// Dispatches each upstream beat to one enabled downstream port chosen by LRU priority.
// Latency: one cycle from upstream accept to downstream valid; 1 beat/cycle sustained.
// Backpressure: rdy_s drops while the hold stage is full and not draining, or no port is enabled.
module arb_vrp_dispatch
  import arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  arb_vrp_dispatch_if.slave bus
);

  logic                 hold_vld;
  logic [PLD_WIDTH-1:0] hold_pld;
  logic [WIDTH-1:0]     hold_sel;
  logic [WIDTH-1:0]     gnt;
  logic                 out_fire;
  logic                 in_fire;

  arb_lru_matrix #(
    .WIDTH (WIDTH)
  ) u_lru (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.v_en),
    .upd   (in_fire),
    .gnt   (gnt)
  );

  assign out_fire  = hold_vld & (|(hold_sel & bus.v_rdy_m));
  assign bus.rdy_s = (|bus.v_en) & (~hold_vld | out_fire);
  assign in_fire   = bus.vld_s & bus.rdy_s;

  // Downstream valid comes only from registered state, never from v_rdy_m.
  assign bus.v_vld_m = hold_sel & {WIDTH{hold_vld}};
  assign bus.v_pld_m = {WIDTH{hold_pld}};

  // The target is latched at capture, so later v_en changes never retarget a held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_pld <= '0;
      hold_sel <= '0;
    end else if (in_fire) begin
      hold_vld <= 1'b1;
      hold_pld <= bus.pld_s;
      hold_sel <= gnt;
    end else if (out_fire) begin
      hold_vld <= 1'b0;
    end
  end

endmodule
